// File: rtl/io_entry_queue_pkg.sv
// io_entry_queue_pkg -- shared types and constants for the CPU input-entry queue.
// Holds the button filter state encoding, the switch bank width and the
// default values of the top-level parameters.
package io_entry_queue_pkg;

    localparam int SW_WIDTH           = 18;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_DEPTH          = 4;
    localparam int DEF_DEB_CYCLES     = 16;

    // Debounce filter states: a level change is accepted only after a run of
    // consecutive stable synchronized samples.
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_DEB   = 2'd1,
        HELD        = 2'd2,
        RELEASE_DEB = 2'd3
    } filt_state_e;

endpackage

// File: rtl/io_entry_queue_if.sv
// io_entry_queue_if -- CPU-side read port of the input-entry queue.
// master = CPU (issues rd_req, observes data and status),
// slave  = queue (answers with head data, stall request and status).
interface io_entry_queue_if
    import io_entry_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
);
    logic                     rd_req;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     wait_flag;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     overflow;

    modport master (
        output rd_req,
        input  rd_data, wait_flag, count, full, overflow
    );

    modport slave (
        input  rd_req,
        output rd_data, wait_flag, count, full, overflow
    );
endinterface

// File: rtl/io_btn_filter.sv
// io_btn_filter -- synchronizes and debounces the raw insert button and emits
// a single-cycle push pulse on each accepted press. Holding the button never
// produces a second pulse; a release must itself be debounced before the
// next press can be accepted.
module io_btn_filter
    import io_entry_queue_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clock,
    input  logic resetn,
    input  logic button,
    output logic push
);

    localparam int            CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic        sync1_q, sync2_q;
    filt_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchronizer for the asynchronous button input.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, which is what makes the
    // two stages a shift chain rather than a single wire.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    // Filter state and run-length counter registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: the sample that leaves a stable state counts as the
    // first of the DEB_CYCLES run, so the push fires on the DEB_CYCLES-th
    // consecutive 1 sample.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_DEB;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_DEB: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    push    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_DEB;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_DEB: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/io_entry_queue.sv
// io_entry_queue -- FIFO of switch-bank words inserted by a debounced button
// and consumed by the CPU input-read instruction. An empty queue stalls the
// CPU through wait_flag; there is no bypass from push to read.
// Optional build macro IO_QUEUE_SIGN_EXT_EN: sign-extend switches[17] into
// the upper bits of each entry instead of zero-extending.
module io_entry_queue
    import io_entry_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                button,
    io_entry_queue_if.slave     cpu
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;

    logic                  push;
    logic [DATA_WIDTH-1:0] push_word;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  empty, is_full, do_pop, do_push;

    io_btn_filter #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_filter (
        .clock  (clock),
        .resetn (resetn),
        .button (button),
        .push   (push)
    );

    // Entry word formed from the switch bank sampled in the push cycle.
    always_comb begin
        push_word                = '0;
        push_word[SW_WIDTH-1:0]  = switches;
`ifdef IO_QUEUE_SIGN_EXT_EN
        for (int i = SW_WIDTH; i < DATA_WIDTH; i++) begin
            push_word[i] = switches[SW_WIDTH-1];
        end
`endif
    end

    // Pointer, occupancy and overflow next-state. A push while full is only
    // dropped when no pop frees a slot in the same cycle.
    always_comb begin
        empty      = (count_q == '0);
        is_full    = (count_q == CNTW'(DEPTH));
        do_pop     = cpu.rd_req && !empty;
        do_push    = push && (!is_full || do_pop);
        overflow_d = overflow_q | (push && is_full && !do_pop);
        wr_ptr_d   = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue storage and control registers; reset wins over push and pop.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            // NOTE: the storage array is cleared on reset as well, so a stale
            // entry can never reappear; this costs a reset path per bit.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_word;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign cpu.rd_data   = empty ? '0 : mem_q[rd_ptr_q];
    assign cpu.wait_flag = cpu.rd_req & empty;
    assign cpu.count     = count_q;
    assign cpu.full      = is_full;
    assign cpu.overflow  = overflow_q;

endmodule

// File: tb/tb_io_entry_queue.sv
// tb_io_entry_queue -- directed and randomized bench for io_entry_queue.
// A behavioural model (accepted button level + run length, word queue)
// predicts every output after each rising edge.
module tb_io_entry_queue;
    import io_entry_queue_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DEB   = 16;
`ifdef IO_QUEUE_SIGN_EXT_EN
    localparam bit SIGN_EXT = 1'b1;
`else
    localparam bit SIGN_EXT = 1'b0;
`endif

    logic                clock    = 1'b0;
    logic                resetn   = 1'b0;
    logic                button   = 1'b0;
    logic [SW_WIDTH-1:0] switches = '0;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [DW-1:0] mq[$];
    bit            m_ovf;
    bit            m_syn1, m_syn2;
    bit            m_acc;
    int            m_run;

    always #5 clock = ~clock;

    io_entry_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) cpu_if ();

    io_entry_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .DEB_CYCLES (DEB)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .switches (switches),
        .button   (button),
        .cpu      (cpu_if)
    );

    function automatic logic [DW-1:0] entry_word(input logic [SW_WIDTH-1:0] sw);
        logic [DW-1:0] w;
        w = DW'(sw);
        if (SIGN_EXT && sw[SW_WIDTH-1]) w = w | ~((DW'(1) << SW_WIDTH) - DW'(1));
        return w;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model reaction to one rising edge, using the inputs held across it.
    task automatic model_edge();
        bit s;
        bit pushed;
        pushed = 1'b0;
        if (!resetn) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_syn1 = 1'b0;
            m_syn2 = 1'b0;
            m_acc  = 1'b0;
            m_run  = 0;
        end else begin
            s      = m_syn2;
            m_syn2 = m_syn1;
            m_syn1 = button;
            if (s != m_acc) begin
                m_run++;
                if (m_run == DEB) begin
                    m_acc  = s;
                    m_run  = 0;
                    pushed = s;
                end
            end else begin
                m_run = 0;
            end
            if (cpu_if.rd_req && mq.size() > 0) void'(mq.pop_front());
            if (pushed) begin
                if (mq.size() < DEPTH) mq.push_back(entry_word(switches));
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check("count",    DW'(cpu_if.count),     DW'(mq.size()));
        check("full",     DW'(cpu_if.full),      DW'(mq.size() == DEPTH));
        check("overflow", DW'(cpu_if.overflow),  DW'(m_ovf));
        check("rd_data",  cpu_if.rd_data,        (mq.size() > 0) ? mq[0] : '0);
        check("wait",     DW'(cpu_if.wait_flag), DW'(cpu_if.rd_req && mq.size() == 0));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            model_edge();
            #1;
            check_outputs();
        end
    endtask

    task automatic press(input logic [SW_WIDTH-1:0] sw, input int hold);
        switches = sw;
        button   = 1'b1;
        step(hold);
        button   = 1'b0;
        step(DEB + 4);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        step(1);
    endtask

    initial begin
        int            len;
        int            rd_rate;
        logic [DW-1:0] exp37;

        // Reset state, with rd_req high to see wait_flag follow it.
        cpu_if.rd_req = 1'b1;
        step(3);
        check("rst_wait", DW'(cpu_if.wait_flag), DW'(1));
        check("rst_data", cpu_if.rd_data, '0);
        resetn        = 1'b1;
        cpu_if.rd_req = 1'b0;
        step(1);

        // Held press gives exactly one entry.
        press(18'h0002A, DEB + 5);
        check("hold_count", DW'(cpu_if.count), DW'(1));
        check("hold_data",  cpu_if.rd_data, 32'h0000002A);

        // Short glitch is rejected.
        do_reset();
        button = 1'b1;
        step(DEB - 1);
        button = 1'b0;
        step(DEB + 4);
        check("glitch_count", DW'(cpu_if.count), DW'(0));

        // Stalled reader, then a press: no bypass, pop the cycle after.
        cpu_if.rd_req = 1'b1;
        step(10);
        check("stall_wait", DW'(cpu_if.wait_flag), DW'(1));
        press(18'h00005, DEB + 5);
        check("stall_count", DW'(cpu_if.count), DW'(0));
        cpu_if.rd_req = 1'b0;
        step(1);

        // Overfill and drain in order.
        for (int i = 1; i <= 5; i++) press(SW_WIDTH'(i), DEB + 3);
        check("ovf_full",  DW'(cpu_if.full),     DW'(1));
        check("ovf_flag",  DW'(cpu_if.overflow), DW'(1));
        cpu_if.rd_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", cpu_if.rd_data, DW'(i));
            step(1);
        end
        check("drain_count", DW'(cpu_if.count), DW'(0));
        cpu_if.rd_req = 1'b0;

        // Top switch bit extension.
        do_reset();
        exp37 = SIGN_EXT ? 32'hFFFE0000 : 32'h00020000;
        press(18'h20000, DEB + 5);
        check("ext_data", cpu_if.rd_data, exp37);

        // Reset in the middle of a press with two entries queued.
        do_reset();
        press(18'h00011, DEB + 5);
        press(18'h00022, DEB + 5);
        check("pre_rst_count", DW'(cpu_if.count), DW'(2));
        switches = 18'h00033;
        button   = 1'b1;
        step(7);
        resetn   = 1'b0;
        button   = 1'b0;
        step(1);
        resetn   = 1'b1;
        check("mid_rst_count", DW'(cpu_if.count),    DW'(0));
        check("mid_rst_ovf",   DW'(cpu_if.overflow), DW'(0));
        step(DEB + 10);
        check("mid_rst_nopush", DW'(cpu_if.count), DW'(0));

        // Randomized segments of button level, switches, reads, rare resets.
        for (int seg = 0; seg < 80; seg++) begin
            button   = 1'($urandom_range(0, 1));
            switches = SW_WIDTH'($urandom);
            len      = $urandom_range(1, 40);
            rd_rate  = $urandom_range(0, 3);
            for (int k = 0; k < len; k++) begin
                cpu_if.rd_req = ($urandom_range(0, 9) < rd_rate);
                resetn        = ($urandom_range(0, 299) != 0);
                step(1);
            end
        end
        resetn = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
